// File: rtl/jtcps1_dma_sched_if.sv
// jtcps1_dma_sched_if
// Bundles every signal of the CPS1 VRAM DMA scheduler apart from clk/rst.
//   Request side : req[2:0] (level, bit0=obj bit1=pal bit2=scr),
//                  obj/pal/scr_base[16:0] block start word addresses,
//                  done[2:0] one-cycle completion pulse per channel
//   CPU bus      : busreq (out), busack (in)
//   SDRAM VRAM   : vram_cs, vram_addr[16:0] (out), vram_data[15:0], vram_ok (in)
//   BRAM write   : wr_en, wr_ch[1:0], wr_addr[11:0], wr_data[15:0] (out)
// The master modport is the scheduler; the slave modport is everything around it.
interface jtcps1_dma_sched_if;
  logic [2:0]  req;
  logic [16:0] obj_base;
  logic [16:0] pal_base;
  logic [16:0] scr_base;
  logic [2:0]  done;
  logic        busreq;
  logic        busack;
  logic        vram_cs;
  logic [16:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ok;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    input  req, obj_base, pal_base, scr_base, busack, vram_data, vram_ok,
    output done, busreq, vram_cs, vram_addr, wr_en, wr_ch, wr_addr, wr_data
  );

  modport slave (
    output req, obj_base, pal_base, scr_base, busack, vram_data, vram_ok,
    input  done, busreq, vram_cs, vram_addr, wr_en, wr_ch, wr_addr, wr_data
  );
endinterface

// File: rtl/jtcps1_dma_sched.sv
// jtcps1_dma_sched
// Frame-time DMA scheduler copying three VRAM blocks (object table, palette,
// row-scroll) from SDRAM into per-channel BRAMs. A block is copied while the
// 68000 bus is held through busreq/busack; the bus is given back after each
// block so the CPU always gets at least one cycle between blocks.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - jtcps1_dma_sched_if.master (request, bus, VRAM and BRAM signals)
// Parameters OBJ_LEN/PAL_LEN/SCR_LEN are block lengths in words, 1..4096.
module jtcps1_dma_sched #(
  parameter int OBJ_LEN = 1024,
  parameter int PAL_LEN = 3072,
  parameter int SCR_LEN = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  jtcps1_dma_sched_if.master         bus
);

  // Index of the last word of each block; the word counter stops here.
  localparam logic [11:0] OBJ_LAST = 12'(OBJ_LEN - 1);
  localparam logic [11:0] PAL_LAST = 12'(PAL_LEN - 1);
  localparam logic [11:0] SCR_LAST = 12'(SCR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSREQ,
    S_ADDR,
    S_MASK,
    S_WAIT,
    S_NEXT,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [16:0] base_q, base_d;
  logic [11:0] last_q, last_d;
  logic [11:0] count_q, count_d;
  logic        busreq_q, busreq_d;
  logic        vram_cs_q, vram_cs_d;
  logic [16:0] vram_addr_q, vram_addr_d;
  logic [2:0]  done_q, done_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  wr_ch_q, wr_ch_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  // Addresses wrap inside the 17-bit VRAM word space with no carry out.
  logic [16:0] word_addr;
  logic [16:0] next_addr;
  logic [11:0] count_inc;

  assign count_inc = count_q + 12'd1;
  assign word_addr = base_q + {5'd0, count_q};
  assign next_addr = base_q + {5'd0, count_inc};

  // Next-state and registered-output logic. Every output is a flop, so each
  // value is prepared here one cycle ahead of the state that shows it.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    base_d      = base_q;
    last_d      = last_q;
    count_d     = count_q;
    busreq_d    = busreq_q;
    vram_cs_d   = vram_cs_q;
    vram_addr_d = vram_addr_q;
    done_d      = 3'b000;
    wr_en_d     = 1'b0;
    wr_ch_d     = wr_ch_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      S_IDLE: begin
        // Fixed priority obj > pal > scr; base and length are frozen here so
        // later changes on the request side cannot disturb a running block.
        if (bus.req != 3'b000 && done_q == 3'b000) begin
          if (bus.req[0]) begin
            ch_d   = 2'd0;
            base_d = bus.obj_base;
            last_d = OBJ_LAST;
          end else if (bus.req[1]) begin
            ch_d   = 2'd1;
            base_d = bus.pal_base;
            last_d = PAL_LAST;
          end else begin
            ch_d   = 2'd2;
            base_d = bus.scr_base;
            last_d = SCR_LAST;
          end
          count_d  = 12'd0;
          busreq_d = 1'b1;
          state_d  = S_BUSREQ;
        end
      end

      S_BUSREQ: begin
        busreq_d = 1'b1;
        if (bus.busack) begin
          vram_cs_d   = 1'b1;
          vram_addr_d = word_addr;
          state_d     = S_ADDR;
        end
      end

      // Losing the bus mid-word abandons the access and retries the same word.
      S_ADDR: begin
        if (!bus.busack) begin
          vram_cs_d = 1'b0;
          state_d   = S_BUSREQ;
        end else begin
          state_d = S_MASK;
        end
      end

      // vram_ok can still be high from the previous access here; skip it.
      S_MASK: begin
        if (!bus.busack) begin
          vram_cs_d = 1'b0;
          state_d   = S_BUSREQ;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!bus.busack) begin
          vram_cs_d = 1'b0;
          state_d   = S_BUSREQ;
        end else if (bus.vram_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.vram_data;
          wr_addr_d = count_q;
          wr_ch_d   = ch_q;
          vram_cs_d = 1'b0;
          state_d   = S_NEXT;
        end
      end

      // The BRAM write for this word is already on the outputs in this state,
      // so a bus loss here only re-reads and rewrites the same word.
      S_NEXT: begin
        if (!bus.busack) begin
          state_d = S_BUSREQ;
        end else if (count_q == last_q) begin
          done_d   = 3'b001 << ch_q;
          count_d  = 12'd0;
          busreq_d = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          count_d     = count_inc;
          vram_cs_d   = 1'b1;
          vram_addr_d = next_addr;
          state_d     = S_ADDR;
        end
      end

      S_RELEASE: begin
        busreq_d = 1'b0;
        if (!bus.busack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= 2'd0;
      base_q      <= 17'd0;
      last_q      <= 12'd0;
      count_q     <= 12'd0;
      busreq_q    <= 1'b0;
      vram_cs_q   <= 1'b0;
      vram_addr_q <= 17'd0;
      done_q      <= 3'b000;
      wr_en_q     <= 1'b0;
      wr_ch_q     <= 2'd0;
      wr_addr_q   <= 12'd0;
      wr_data_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      base_q      <= base_d;
      last_q      <= last_d;
      count_q     <= count_d;
      busreq_q    <= busreq_d;
      vram_cs_q   <= vram_cs_d;
      vram_addr_q <= vram_addr_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_ch_q     <= wr_ch_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.busreq    = busreq_q;
  assign bus.vram_cs   = vram_cs_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.done      = done_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_ch     = wr_ch_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule
